// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR,
        RF_RUN
    } rf_state_t;

    // Address width for a register count; at least one bit.
    function automatic int unsigned rf_addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-side bus of the multi-port register file.
interface regfile_mp_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned NREAD  = 2,
    parameter int unsigned NWRITE = 1
);
    import regfile_pkg::*;

    localparam int unsigned AW = rf_addr_width(DEPTH);

    logic [NREAD*AW-1:0]     rdAddr;
    logic [NREAD*WIDTH-1:0]  rdData;
    logic [NREAD-1:0]        rdBusy;
    logic [NWRITE-1:0]       wrEn;
    logic [NWRITE*AW-1:0]    wrAddr;
    logic [NWRITE*WIDTH-1:0] wrData;
    logic                    busySetEn;
    logic [AW-1:0]           busySetAddr;
    logic                    ready;

    modport master (
        output rdAddr, wrEn, wrAddr, wrData, busySetEn, busySetAddr,
        input  rdData, rdBusy, ready
    );

    modport slave (
        input  rdAddr, wrEn, wrAddr, wrData, busySetEn, busySetAddr,
        output rdData, rdBusy, ready
    );

endinterface

// File: rtl/regfile_bypass.sv
// Next read data for one read port: write-first bypass with highest-port priority.
module regfile_bypass #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned NWRITE   = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic [AW-1:0]           rd_addr,
    input  logic [NWRITE-1:0]       wr_en,
    input  logic [NWRITE*AW-1:0]    wr_addr,
    input  logic [NWRITE*WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0]        arr_data,
    output logic [WIDTH-1:0]        rd_data
);

    always_comb begin
        rd_data = arr_data;
        // Ascending scan so the highest matching port is the last to assign.
        for (int unsigned p = 0; p < NWRITE; p++) begin
            if (wr_en[p] && (wr_addr[p*AW +: AW] == rd_addr)) begin
                rd_data = wr_data[p*WIDTH +: WIDTH];
            end
        end
        if ((ZERO_REG != 0) && (rd_addr == '0)) begin
            rd_data = '0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: registered reads with write-first bypass,
// per-register busy scoreboard and a post-reset zeroing sweep.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NREAD    = 2,
    parameter int unsigned NWRITE   = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_mp_if.slave  bus
);

    localparam int unsigned AW = rf_addr_width(DEPTH);

    rf_state_t              state, state_next;
    logic [AW-1:0]          cnt;
    logic [WIDTH-1:0]       mem [DEPTH];
    logic [NWRITE-1:0]      wr_live;
    logic [DEPTH-1:0]       busy, busy_next;
    logic [NREAD*WIDTH-1:0] rd_next;
    logic [NREAD-1:0]       rd_busy_next;
    logic [NREAD*WIDTH-1:0] rd_data_q;
    logic [NREAD-1:0]       rd_busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RF_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == RF_CLEAR) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        if ((state == RF_CLEAR) && (cnt == AW'(DEPTH - 1))) begin
            state_next = RF_RUN;
        end
    end

    // Writes that actually land: only in RUN, and never to a hardwired r0.
    always_comb begin
        wr_live = '0;
        for (int unsigned p = 0; p < NWRITE; p++) begin
            wr_live[p] = bus.wrEn[p] && (state == RF_RUN) &&
                         !((ZERO_REG != 0) && (bus.wrAddr[p*AW +: AW] == '0));
        end
    end

    always_ff @(posedge clk) begin
        if (state == RF_CLEAR) begin
            mem[cnt] <= '0;
        end else begin
            for (int unsigned p = 0; p < NWRITE; p++) begin
                if (wr_live[p]) begin
                    mem[bus.wrAddr[p*AW +: AW]] <= bus.wrData[p*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Clears from writes first, then the set, so a same-edge set wins.
    always_comb begin
        busy_next = busy;
        if (state == RF_RUN) begin
            for (int unsigned p = 0; p < NWRITE; p++) begin
                if (wr_live[p]) begin
                    busy_next[bus.wrAddr[p*AW +: AW]] = 1'b0;
                end
            end
            if (bus.busySetEn) begin
                busy_next[bus.busySetAddr] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            busy_next[0] = 1'b0;
        end
    end

    always_comb begin
        rd_busy_next = '0;
        for (int unsigned i = 0; i < NREAD; i++) begin
            rd_busy_next[i] = busy_next[bus.rdAddr[i*AW +: AW]];
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [WIDTH-1:0] arr_rd;
        assign arr_rd = mem[bus.rdAddr[i*AW +: AW]];

        regfile_bypass #(
            .WIDTH    (WIDTH),
            .AW       (AW),
            .NWRITE   (NWRITE),
            .ZERO_REG (ZERO_REG)
        ) u_bypass (
            .rd_addr  (bus.rdAddr[i*AW +: AW]),
            .wr_en    (wr_live),
            .wr_addr  (bus.wrAddr),
            .wr_data  (bus.wrData),
            .arr_data (arr_rd),
            .rd_data  (rd_next[i*WIDTH +: WIDTH])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= '0;
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            busy <= busy_next;
            if (state == RF_CLEAR) begin
                rd_data_q <= '0;
                rd_busy_q <= '0;
            end else begin
                rd_data_q <= rd_next;
                rd_busy_q <= rd_busy_next;
            end
        end
    end

    assign bus.rdData = rd_data_q;
    assign bus.rdBusy = rd_busy_q;
    assign bus.ready  = (state == RF_RUN);

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp (32x32, 2 read, 2 write ports, r0 hardwired).
module tb_regfile_mp;

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic        b0;
        logic        b1;
        logic        rdy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_mp_if #(.WIDTH(32), .DEPTH(32), .NREAD(2), .NWRITE(2)) bus ();

    regfile_mp #(
        .WIDTH    (32),
        .DEPTH    (32),
        .NREAD    (2),
        .NWRITE   (2),
        .ZERO_REG (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    exp_t q[$];
    exp_t mon_e;

    // Stimulus for the next edge
    logic       rst_i;
    logic [4:0] ra [2];
    logic       we [2];
    logic [4:0] wa [2];
    logic [31:0] wd [2];
    logic       bse;
    logic [4:0] bsa;

    // Reference model: contents, pending flags and sweep progress
    logic [31:0] m_mem [32];
    bit          m_busy [32];
    int          m_edges = 0;
    bit          m_ready = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic idle();
        we[0] = 1'b0; we[1] = 1'b0;
        wa[0] = '0;   wa[1] = '0;
        wd[0] = '0;   wd[1] = '0;
        ra[0] = '0;   ra[1] = '0;
        bse = 1'b0;   bsa = '0;
    endtask

    task automatic tick();
        exp_t e;
        logic prev;
        @(negedge clk);
        prev = rst_n;
        rst_n = rst_i;
        bus.rdAddr = {ra[1], ra[0]};
        bus.wrEn = {we[1], we[0]};
        bus.wrAddr = {wa[1], wa[0]};
        bus.wrData = {wd[1], wd[0]};
        bus.busySetEn = bse;
        bus.busySetAddr = bsa;
        if (prev && !rst_i) begin
            #1;
            chk("ready_drop", {31'b0, bus.ready}, 32'd0);
            chk("rd_zero_on_reset", bus.rdData[31:0], 32'd0);
        end
        e.d0 = '0; e.d1 = '0; e.b0 = 1'b0; e.b1 = 1'b0; e.rdy = 1'b0;
        if (!rst_i) begin
            m_edges = 0;
            m_ready = 0;
            foreach (m_busy[k]) m_busy[k] = 0;
        end else if (!m_ready) begin
            m_edges++;
            if (m_edges == 32) begin
                m_ready = 1;
                foreach (m_mem[k]) m_mem[k] = '0;
                foreach (m_busy[k]) m_busy[k] = 0;
            end
            e.rdy = m_ready;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (we[p] && wa[p] != 0) begin
                    m_mem[wa[p]] = wd[p];
                    m_busy[wa[p]] = 0;
                end
            end
            if (bse) m_busy[bsa] = 1;
            m_busy[0] = 0;
            e.d0 = (ra[0] == 0) ? 32'd0 : m_mem[ra[0]];
            e.d1 = (ra[1] == 0) ? 32'd0 : m_mem[ra[1]];
            e.b0 = m_busy[ra[0]];
            e.b1 = m_busy[ra[1]];
            e.rdy = 1'b1;
        end
        q.push_back(e);
        idle();
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            chk("rdData0", bus.rdData[31:0], mon_e.d0);
            chk("rdData1", bus.rdData[63:32], mon_e.d1);
            chk("rdBusy0", {31'b0, bus.rdBusy[0]}, {31'b0, mon_e.b0});
            chk("rdBusy1", {31'b0, bus.rdBusy[1]}, {31'b0, mon_e.b1});
            chk("ready", {31'b0, bus.ready}, {31'b0, mon_e.rdy});
        end
    end

    task automatic sweep_and_read_all();
        rst_i = 1'b1;
        for (int k = 0; k < 32; k++) begin
            ra[0] = 5'($urandom_range(31, 0));
            ra[1] = 5'($urandom_range(31, 0));
            we[0] = 1'b1; wa[0] = 5'd4; wd[0] = $urandom;
            bse = 1'b1; bsa = 5'd6;
            tick();
        end
        for (int k = 0; k < 16; k++) begin
            ra[0] = 5'(2 * k);
            ra[1] = 5'(2 * k + 1);
            tick();
        end
    endtask

    initial begin
        idle();
        rst_i = 1'b0;
        bus.rdAddr = '0; bus.wrEn = '0; bus.wrAddr = '0; bus.wrData = '0;
        bus.busySetEn = 1'b0; bus.busySetAddr = '0;

        repeat (3) tick();
        sweep_and_read_all();

        // Write with same-edge bypass, then a later read
        we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'hDEADBEEF; ra[0] = 5'd5;
        tick();
        tick();
        ra[0] = 5'd5; ra[1] = 5'd5;
        tick();

        // Hardwired zero register
        we[0] = 1'b1; wa[0] = 5'd0; wd[0] = 32'h12345678;
        bse = 1'b1; bsa = 5'd0; ra[0] = 5'd0;
        tick();
        ra[0] = 5'd0; ra[1] = 5'd0;
        tick();

        // Write-port conflict: higher port wins
        we[0] = 1'b1; wa[0] = 5'd7; wd[0] = 32'h0000AAAA;
        we[1] = 1'b1; wa[1] = 5'd7; wd[1] = 32'h0000BBBB;
        ra[1] = 5'd7;
        tick();
        ra[0] = 5'd7;
        tick();

        // Scoreboard set, write-clear, set-beats-write
        bse = 1'b1; bsa = 5'd9;
        tick();
        ra[0] = 5'd9;
        tick();
        we[1] = 1'b1; wa[1] = 5'd9; wd[1] = 32'h99; ra[0] = 5'd9;
        tick();
        ra[1] = 5'd9;
        tick();
        we[0] = 1'b1; wa[0] = 5'd9; wd[0] = 32'h1234; bse = 1'b1; bsa = 5'd9;
        ra[0] = 5'd9;
        tick();
        ra[1] = 5'd9;
        tick();

        // Randomised traffic concentrated on a few registers
        for (int k = 0; k < 250; k++) begin
            ra[0] = 5'($urandom_range(15, 0));
            ra[1] = 5'($urandom_range(15, 0));
            we[0] = 1'($urandom_range(1, 0));
            we[1] = 1'($urandom_range(1, 0));
            wa[0] = 5'($urandom_range(15, 0));
            wa[1] = ($urandom_range(3, 0) == 0) ? wa[0] : 5'($urandom_range(15, 0));
            wd[0] = $urandom;
            wd[1] = $urandom;
            bse = ($urandom_range(2, 0) == 0);
            bsa = 5'($urandom_range(15, 0));
            tick();
        end

        // Reset after 10 sweep edges
        rst_i = 1'b0;
        repeat (2) tick();
        rst_i = 1'b1;
        repeat (10) tick();
        rst_i = 1'b0;
        tick();
        sweep_and_read_all();

        // Reset in RUN after writing r3
        we[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'h55; ra[0] = 5'd3;
        tick();
        ra[1] = 5'd3;
        tick();
        rst_i = 1'b0;
        tick();
        sweep_and_read_all();
        ra[0] = 5'd3;
        tick();

        @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
